// File: rtl/n2_seq_mul8_ctrl.sv
// n2_seq_mul8_ctrl
// Sequential 8x8 approximate multiplier. One N2 approximate 4x4 core is
// time-shared over four cycles using the recursive split
//   AL*BL + (AH*BL + AL*BH)<<4 + AH*BH<<8
// with the partial products summed exactly in a 16-bit accumulator.
//
// State | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | one core evaluation per cycle, step s=0..3
// DONE  | product on p, out_valid=1 until the sink takes it
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready/a/b operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready/p result handshake, p = approximate product
//   busy                  high while an operation is in flight (MUL or DONE)
//   op_count              delivered products, wraps at 2^CNT_W
//
// Build option: define N2_EXACT_HH_EN to compute the AH*BH term with an
// exact 4x4 product; the other three terms always use the approximate core.
module n2_seq_mul8_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  x, y;
  logic [7:0]  core_out;
  logic [7:0]  term;
  logic [3:0]  shift;
  logic [15:0] term_sh;

  // Operand select: s[0] picks the high nibble of a, s[1] the high nibble of b.
  always_comb begin
    x = s_q[0] ? a_q[7:4] : a_q[3:0];
    y = s_q[1] ? b_q[7:4] : b_q[3:0];
    case (s_q)
      2'd0:    shift = 4'd0;
      2'd3:    shift = 4'd8;
      default: shift = 4'd4;
    endcase
  end

  // N2 core: each partial-product column is ORed; the top column x3y3 is
  // split into bits 6/7 depending on x2y2 to recover some of the lost carry.
  always_comb begin
    core_out[0] = x[0] & y[0];
    core_out[1] = (x[0] & y[1]) | (x[1] & y[0]);
    core_out[2] = (x[0] & y[2]) | (x[1] & y[1]) | (x[2] & y[0]);
    core_out[3] = (x[0] & y[3]) | (x[1] & y[2]) | (x[2] & y[1]) | (x[3] & y[0]);
    core_out[4] = (x[1] & y[3]) | (x[2] & y[2]) | (x[3] & y[1]);
    core_out[5] = (x[2] & y[3]) | (x[3] & y[2]);
    core_out[6] = (x[3] & y[3]) & ~(x[2] & y[2]);
    core_out[7] = (x[3] & y[3]) & (x[2] & y[2]);
  end

`ifdef N2_EXACT_HH_EN
  always_comb begin
    if (s_q == 2'd3) begin
      term = {4'b0, x} * {4'b0, y};
    end else begin
      term = core_out;
    end
  end
`else
  always_comb begin
    term = core_out;
  end
`endif

  always_comb begin
    term_sh = {8'b0, term} << shift;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MUL;
          a_d     = a;
          b_d     = b;
          acc_d   = 16'd0;
          s_d     = 2'd0;
        end
      end
      MUL: begin
        // Partial sums never exceed 63903, so no overflow handling is needed.
        acc_d = acc_q + term_sh;
        s_d   = s_q + 2'd1;
        if (s_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = acc_q;
  assign op_count  = cnt_q;

endmodule

// File: doc/n2_seq_mul8_ctrl.md
# n2_seq_mul8_ctrl

Sequential controller that builds an 8x8 approximate product by time-sharing one N2 approximate 4x4 multiplier core (`n2_4x4`) over four cycles. It follows the recursive decomposition AL·BL + (AH·BL + AL·BH)<<4 + AH·BH<<8. It sits between a valid/ready operand source and a valid/ready result sink. It trades throughput for area against the fully parallel recursive 8x8 arrangement.

## Interface
- `CNT_W`, 16 — width of the completed-operation counter.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — operand pair valid.
- `in_ready` out 1 — controller can accept operands.
- `a` in 8 — multiplicand.
- `b` in 8 — multiplier.
- `out_valid` out 1 — product valid.
- `out_ready` in 1 — sink accepts product.
- `p` out 16 — approximate product.
- `busy` out 1 — high in `MUL` or `DONE`.
- `op_count` out `CNT_W` — number of products delivered, i.e. out handshakes.

## Operation
- States:
  - `IDLE`: `in_ready`=1.
  - `MUL`: 2-bit step counter `s` = 0..3.
  - `DONE`: `out_valid`=1.
- `IDLE` → `MUL` on `in_valid & in_ready`:
  - `a` and `b` are latched into operand registers.
  - The accumulator `acc` (16 bits) is cleared.
  - `s` is set to 0.
- In `MUL`, one core evaluation is made per cycle. The core inputs are muxed by `s`, and `acc` is updated with `acc + (core_out << shift)`:
  - s=0: AL·BL, shift 0.
  - s=1: AH·BL, shift 4.
  - s=2: AL·BH, shift 4.
  - s=3: AH·BH, shift 8.
- `MUL` → `DONE` after s=3 has been accumulated. Otherwise `s` increments.
- `DONE` → `IDLE` on `out_valid & out_ready`. On that edge `op_count` increments; it wraps modulo 2^`CNT_W`.
- Core behaviour for a 4x4 operand pair (x, y):
  - Partial-product columns are ORed, not added.
  - Y6 = x3y3 & ~(x2y2).
  - Y7 = x3y3 & x2y2.
- Arithmetic: the sum of the four partials is exact in `acc`, with a maximum of 63903 and no overflow. The only approximation comes from the core.
- `p` is driven from `acc` and is held stable in `DONE` until the handshake completes.
- Changes on `a`/`b`/`in_valid` after acceptance are ignored until the controller returns to `IDLE`.
- `in_ready` is 0 in `MUL` and `DONE`. There is no accept-while-done; at most one operation is in flight.
- `out_ready` held high in `DONE`: the transfer occurs on the first `DONE` cycle.
- `out_ready` low: `DONE` holds indefinitely, and `p`/`out_valid` stay stable.

## Timing
- Reset values:
  - State `IDLE`.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `p`=0, `acc`=0, `s`=0, `op_count`=0.
- Accept edge at cycle T:
  - `MUL` runs on cycles T+1..T+4.
  - `out_valid`=1 from T+5.
- Minimum accept-to-accept interval: 6 cycles, when `out_ready` is held high.
- `rst` during `MUL` or `DONE`: the operation is aborted with no output, and all registers return to their reset values on the next edge.
- `rst` has priority over every handshake in the same cycle.
- All outputs are registered or state-decoded. There is no combinational path from `out_ready`/`in_valid` to any output.

## Configuration
- `N2_EXACT_HH_EN` defined:
  - The s=3 term AH·BH uses an exact 4x4 product (full adder-based, 8-bit) instead of the approximate core.
  - The other three terms still use the core.
  - This reduces error on large operands.
- Undefined: all four terms use the approximate core.
- Timing, handshake and state machine are identical in both builds.

## Test plan
- Reset, then a=8'h03, b=8'h05 → `p`=16'h000F, `out_valid` at T+5, `op_count`=1 after the handshake (identical in both builds).
- a=8'hFF, b=8'hFF → `p`=16'hD79F without the macro. With `N2_EXACT_HH_EN`, `p`=16'hF99F.
- a=8'hFF, b=8'hFF with `out_ready` low for 10 cycles after `out_valid` → `p` and `out_valid` stable, `in_ready`=0 throughout, single transfer when `out_ready` rises.
- Toggle `a`/`b` randomly during `MUL` after accepting a=8'h03, b=8'h05 → result still 16'h000F.
- Assert `rst` at T+3 mid-operation → all outputs at reset values next cycle, no `out_valid`, `op_count` unchanged at 0; next operation a=8'h03, b=8'h05 yields 16'h000F.
- Back-to-back: hold `in_valid`=1 and `out_ready`=1 for 3 operations → accepts exactly 6 cycles apart, `op_count`=3.
